// File: rtl/jtag_dr_pkg.sv
// Shared types and constants for the JTAGG user data register bridge.
package jtag_dr_pkg;

   // Default data register width
   localparam int DW_DEF = 32;

   // Width of the saturating overrun counter
   localparam int OVR_W = 8;

   // Shift-side state: IDLE between transfers, CAPTURE right after a load,
   // SHIFT while bits move through the register.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SHIFT   = 2'd2
   } dr_state_e;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] val);
      logic [OVR_W-1:0] res;
      if (val == {OVR_W{1'b1}}) begin
         res = val;
      end else begin
         res = val + {{(OVR_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/jtag_sync.sv
// Single-bit multi-flop synchronizer for the asynchronous JTAGG outputs.
// The reset value is a parameter so that active-low inputs can idle inactive.
module jtag_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff_r;

   // Shift the raw input through the synchronizer chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff_r <= {STAGES{RST_VAL}};
      end else begin
         ff_r <= {ff_r[STAGES-2:0], d};
      end
   end

   assign q = ff_r[STAGES-1];

endmodule

// File: rtl/jtag_dr_bridge.sv
// Bridge between the ECP5 JTAGG ER1/ER2 user data registers and the SoC
// debug register port. The JTAG signals are oversampled in the clk48m domain,
// a rising TCK is detected as an event, and the capture/shift/update actions
// run on that event. Updated words land in a valid/ready holding register
// that counts words lost to overwrite.
module jtag_dr_bridge
   import jtag_dr_pkg::*;
#(
   parameter int DW          = DW_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             jtck,
   input  logic             jtdi,
   input  logic             jshift,
   input  logic             jupdate,
   input  logic             jce1,
   input  logic             jce2,
   input  logic             jrstn,
   output logic             jtdo1,
   output logic             jtdo2,
   input  logic [DW-1:0]    tx_data,
   output logic             tx_ack,
   output logic [DW-1:0]    rx_data,
   output logic             rx_sel,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [OVR_W-1:0] overrun_cnt
);

   // Synchronized JTAG inputs
   logic jtck_s;
   logic jtdi_s;
   logic jshift_s;
   logic jupdate_s;
   logic jce1_s;
   logic jce2_s;
   logic jrstn_s;

   // Decoded control
   logic tck_ev_s;
   logic jce_s;
   logic cap_s;
   logic shf_s;
   logic upd_s;

   // Next-state values for the shift side
   dr_state_e      state_nxt_s;
   logic [DW-1:0]  sr_nxt_s;
   logic           sel_nxt_s;
   logic           tdo1_nxt_s;
   logic           tdo2_nxt_s;

   // Registered state
   dr_state_e         state_r;
   logic              jtck_d_r;
   logic [DW-1:0]     sr_r;
   logic              sel_r;
   logic              jtdo1_r;
   logic              jtdo2_r;
   logic              tx_ack_r;
   logic [DW-1:0]     rx_data_r;
   logic              rx_sel_r;
   logic              rx_valid_r;
   logic [OVR_W-1:0]  ovr_cnt_r;

   jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tck (
      .clk(clk), .rst(rst), .d(jtck), .q(jtck_s)
   );
   jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tdi (
      .clk(clk), .rst(rst), .d(jtdi), .q(jtdi_s)
   );
   jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_shift (
      .clk(clk), .rst(rst), .d(jshift), .q(jshift_s)
   );
   jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_update (
      .clk(clk), .rst(rst), .d(jupdate), .q(jupdate_s)
   );
   jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ce1 (
      .clk(clk), .rst(rst), .d(jce1), .q(jce1_s)
   );
   jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ce2 (
      .clk(clk), .rst(rst), .d(jce2), .q(jce2_s)
   );
   // jrstn idles high through reset so rst alone never looks like a TAP reset
   jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rstn (
      .clk(clk), .rst(rst), .d(jrstn), .q(jrstn_s)
   );

   assign tck_ev_s = jtck_s & ~jtck_d_r;
   assign jce_s    = jce1_s | jce2_s;

   // Next-state and action decode on each TCK event
   always_comb begin
      state_nxt_s = state_r;
      cap_s       = 1'b0;
      shf_s       = 1'b0;
      upd_s       = 1'b0;
      if (!jrstn_s) begin
         state_nxt_s = IDLE;
      end else if (tck_ev_s) begin
         case (state_r)
            IDLE: begin
               if (jce_s && !jshift_s) begin
                  state_nxt_s = CAPTURE;
                  cap_s       = 1'b1;
               end else if (jce_s && jshift_s) begin
                  state_nxt_s = SHIFT;
                  shf_s       = 1'b1;
               end else if (jupdate_s) begin
                  state_nxt_s = IDLE;
                  upd_s       = 1'b1;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            CAPTURE, SHIFT: begin
               if (jce_s && jshift_s) begin
                  state_nxt_s = SHIFT;
                  shf_s       = 1'b1;
               end else if (jupdate_s) begin
                  state_nxt_s = IDLE;
                  upd_s       = 1'b1;
               end else if (jce_s) begin
                  // A fresh Capture-DR always reloads, whatever came before
                  state_nxt_s = CAPTURE;
                  cap_s       = 1'b1;
               end else begin
                  // Exit/Pause: drop back without touching the register
                  state_nxt_s = IDLE;
               end
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Shift-register datapath and TDO values for the next cycle
   always_comb begin
      sr_nxt_s  = sr_r;
      sel_nxt_s = sel_r;
      if (!jrstn_s) begin
         sr_nxt_s  = {DW{1'b0}};
         sel_nxt_s = 1'b0;
      end else if (cap_s) begin
         sr_nxt_s  = tx_data;
         sel_nxt_s = jce2_s;
      end else if (shf_s) begin
         sr_nxt_s = {jtdi_s, sr_r[DW-1:1]};
         if (state_r == IDLE) begin
            sel_nxt_s = jce2_s;
         end else begin
            sel_nxt_s = sel_r;
         end
      end else begin
         sr_nxt_s  = sr_r;
         sel_nxt_s = sel_r;
      end
      // TDO is only driven while a transfer is in progress
      if (state_nxt_s != IDLE) begin
         tdo1_nxt_s = sr_nxt_s[0] & ~sel_nxt_s;
         tdo2_nxt_s = sr_nxt_s[0] & sel_nxt_s;
      end else begin
         tdo1_nxt_s = 1'b0;
         tdo2_nxt_s = 1'b0;
      end
   end

   // All bridge state: FSM, shift register, TDO, holding register, counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         jtck_d_r   <= 1'b0;
         sr_r       <= {DW{1'b0}};
         sel_r      <= 1'b0;
         jtdo1_r    <= 1'b0;
         jtdo2_r    <= 1'b0;
         tx_ack_r   <= 1'b0;
         rx_data_r  <= {DW{1'b0}};
         rx_sel_r   <= 1'b0;
         rx_valid_r <= 1'b0;
         ovr_cnt_r  <= {OVR_W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         jtck_d_r <= jtck_s;
         sr_r     <= sr_nxt_s;
         sel_r    <= sel_nxt_s;
         jtdo1_r  <= tdo1_nxt_s;
         jtdo2_r  <= tdo2_nxt_s;
         tx_ack_r <= cap_s;
         if (upd_s) begin
            // A same-cycle handshake consumes the old word, so no loss
            rx_data_r  <= sr_r;
            rx_sel_r   <= sel_r;
            rx_valid_r <= 1'b1;
            if (rx_valid_r && !rx_ready) begin
               ovr_cnt_r <= sat_inc(ovr_cnt_r);
            end else begin
               ovr_cnt_r <= ovr_cnt_r;
            end
         end else if (rx_valid_r && rx_ready) begin
            rx_valid_r <= 1'b0;
         end else begin
            rx_valid_r <= rx_valid_r;
         end
      end
   end

   assign jtdo1       = jtdo1_r;
   assign jtdo2       = jtdo2_r;
   assign tx_ack      = tx_ack_r;
   assign rx_data     = rx_data_r;
   assign rx_sel      = rx_sel_r;
   assign rx_valid    = rx_valid_r;
   assign overrun_cnt = ovr_cnt_r;

endmodule

// File: tb/tb_jtag_dr_bridge.sv
// Directed bench for jtag_dr_bridge: table of full DR transfers at TCK=1 MHz
// plus hand-written TAP-reset and async-reset abort sequences.
module tb_jtag_dr_bridge;

   localparam int DW   = 32;
   localparam int SS   = 2;
   localparam int HALF = 25;   // clk cycles per TCK half period

   logic          clk;
   logic          rst;
   logic          jtck, jtdi, jshift, jupdate, jce1, jce2, jrstn;
   logic          jtdo1, jtdo2;
   logic [DW-1:0] tx_data;
   logic          tx_ack;
   logic [DW-1:0] rx_data;
   logic          rx_sel;
   logic          rx_valid;
   logic          rx_ready;
   logic [7:0]    overrun_cnt;

   int checks = 0;
   int errors = 0;
   int ack_cnt = 0;

   // Results of the last transfer / update
   logic [31:0] xfer_seq;
   int          xfer_other;
   int          xfer_ack;
   logic [31:0] snap_data;
   logic        snap_sel;
   logic        snap_valid;
   logic [7:0]  snap_ovr;
   logic        snap_tdo;

   typedef struct {
      logic        er2;
      logic [31:0] wdata;
      logic [31:0] txd;
      logic        pre;     // consume pending word before the transfer
      logic        simul;   // handshake lands on the update cycle
      logic        post;    // consume after the transfer
      logic [31:0] exp_data;
      logic        exp_sel;
      logic [7:0]  exp_ovr;
   } vec_t;

   vec_t vecs [7];

   jtag_dr_bridge #(.DW(DW), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst),
      .jtck(jtck), .jtdi(jtdi), .jshift(jshift), .jupdate(jupdate),
      .jce1(jce1), .jce2(jce2), .jrstn(jrstn),
      .jtdo1(jtdo1), .jtdo2(jtdo2),
      .tx_data(tx_data), .tx_ack(tx_ack),
      .rx_data(rx_data), .rx_sel(rx_sel), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .overrun_cnt(overrun_cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Count tx_ack pulses away from the active edge
   always @(negedge clk) begin
      if (tx_ack) ack_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full TCK period; TDO sampled late in the high phase
   task automatic tck(input logic ce1, input logic ce2, input logic sh, input logic upd,
                      input logic tdi, output logic t1, output logic t2);
      jce1 = ce1; jce2 = ce2; jshift = sh; jupdate = upd; jtdi = tdi;
      repeat (HALF) @(posedge clk);
      #2 jtck = 1'b1;
      repeat (HALF - 1) @(posedge clk);
      #1 t1 = jtdo1; t2 = jtdo2;
      @(posedge clk);
      #2 jtck = 1'b0;
   endtask

   // Update-DR TCK period; snapshots the holding register after the event
   task automatic upd_cycle(input logic simul, input logic [31:0] exp_d);
      int n;
      jce1 = 1'b0; jce2 = 1'b0; jshift = 1'b0; jupdate = 1'b1; jtdi = 1'b0;
      repeat (HALF) @(posedge clk);
      #2 jtck = 1'b1;
      if (simul) begin
         // Raise ready in the cycle the update event is recognised
         repeat (SS) @(posedge clk);
         #2 rx_ready = 1'b1;
         n = 0;
         while (rx_data !== exp_d && n < 8) begin
            @(posedge clk);
            #1 n++;
         end
         rx_ready = 1'b0;
         chk("simul_upd_seen", 32'(n < 8), 32'd1);
         repeat (2) @(posedge clk);
         #1;
      end else begin
         repeat (SS + 2) @(posedge clk);
         #1;
      end
      snap_data = rx_data; snap_sel = rx_sel; snap_valid = rx_valid; snap_ovr = overrun_cnt;
      repeat (12) @(posedge clk);
      #1 snap_tdo = jtdo1 | jtdo2;
      @(posedge clk);
      #2 jtck = 1'b0; jupdate = 1'b0;
   endtask

   // Capture, 32 LSB-first shifts, update, one Run-Test/Idle period
   task automatic xfer(input logic er2, input logic [31:0] wdata, input logic simul,
                       input logic [31:0] exp_d);
      logic t1, t2;
      int a0;
      a0 = ack_cnt;
      xfer_seq = 32'd0;
      xfer_other = 0;
      tck(~er2, er2, 1'b0, 1'b0, 1'b0, t1, t2);
      xfer_seq[0] = er2 ? t2 : t1;
      xfer_other += int'(er2 ? t1 : t2);
      for (int k = 0; k < 32; k++) begin
         tck(~er2, er2, 1'b1, 1'b0, wdata[k], t1, t2);
         if (k < 31) xfer_seq[k+1] = er2 ? t2 : t1;
         xfer_other += int'(er2 ? t1 : t2);
      end
      upd_cycle(simul, exp_d);
      tck(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t1, t2);
      xfer_ack = ack_cnt - a0;
   endtask

   // Single-clk ready pulse, then check the word was consumed
   task automatic consume(input string name);
      @(posedge clk);
      #2 rx_ready = 1'b1;
      @(posedge clk);
      #2 rx_ready = 1'b0;
      chk(name, 32'(rx_valid), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_jtdo1"}, 32'(jtdo1), 32'd0);
      chk({tag, "_jtdo2"}, 32'(jtdo2), 32'd0);
      chk({tag, "_tx_ack"}, 32'(tx_ack), 32'd0);
      chk({tag, "_rx_data"}, rx_data, 32'd0);
      chk({tag, "_rx_sel"}, 32'(rx_sel), 32'd0);
      chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, "_ovr"}, 32'(overrun_cnt), 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic t1, t2;
      vecs[0] = '{1'b0, 32'hDEADBEEF, 32'h13579BDF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 8'd0};
      vecs[1] = '{1'b1, 32'h00000000, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 8'd0};
      vecs[2] = '{1'b0, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001, 1'b0, 8'd0};
      vecs[3] = '{1'b0, 32'h00000002, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000002, 1'b0, 8'd1};
      vecs[4] = '{1'b0, 32'h00000003, 32'h80000001, 1'b0, 1'b0, 1'b1, 32'h00000003, 1'b0, 8'd2};
      vecs[5] = '{1'b0, 32'h0000005A, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h0000005A, 1'b0, 8'd2};
      vecs[6] = '{1'b0, 32'h000000A5, 32'h0000FFFF, 1'b0, 1'b1, 1'b0, 32'h000000A5, 1'b0, 8'd2};

      rst = 1'b1;
      jtck = 1'b0; jtdi = 1'b0; jshift = 1'b0; jupdate = 1'b0;
      jce1 = 1'b0; jce2 = 1'b0; jrstn = 1'b1;
      tx_data = 32'd0; rx_ready = 1'b0;
      #1;
      chk_all_zero("reset");
      repeat (4) @(posedge clk);
      #3 rst = 1'b0;
      repeat (6) @(posedge clk);

      for (int i = 0; i < 7; i++) begin
         tx_data = vecs[i].txd;
         if (vecs[i].pre) consume($sformatf("v%0d_pre_consume", i));
         xfer(vecs[i].er2, vecs[i].wdata, vecs[i].simul, vecs[i].exp_data);
         chk($sformatf("v%0d_rx_data", i), snap_data, vecs[i].exp_data);
         chk($sformatf("v%0d_rx_sel", i), 32'(snap_sel), 32'(vecs[i].exp_sel));
         chk($sformatf("v%0d_rx_valid", i), 32'(snap_valid), 32'd1);
         chk($sformatf("v%0d_ovr", i), 32'(snap_ovr), 32'(vecs[i].exp_ovr));
         chk($sformatf("v%0d_tdo_seq", i), xfer_seq, vecs[i].txd);
         chk($sformatf("v%0d_tdo_other", i), 32'(xfer_other), 32'd0);
         chk($sformatf("v%0d_tdo_idle", i), 32'(snap_tdo), 32'd0);
         chk($sformatf("v%0d_tx_ack", i), 32'(xfer_ack), 32'd1);
         if (vecs[i].post) consume($sformatf("v%0d_post_consume", i));
      end

      // TAP reset after 10 shifts: partial word discarded, no update
      consume("jr_pre_consume");
      tx_data = 32'h0;
      tck(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, t1, t2);
      for (int k = 0; k < 10; k++) tck(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, t1, t2);
      jrstn = 1'b0;
      tck(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t1, t2);
      tck(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t1, t2);
      jrstn = 1'b1;
      tck(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t1, t2);
      chk("jr_rx_data_kept", rx_data, 32'h000000A5);
      chk("jr_rx_valid_kept", 32'(rx_valid), 32'd0);
      chk("jr_tdo1", 32'(jtdo1), 32'd0);
      // A bare update republishes the (cleared) shift register
      upd_cycle(1'b0, 32'd0);
      chk("jr_bare_upd_data", snap_data, 32'd0);
      chk("jr_bare_upd_valid", 32'(snap_valid), 32'd1);
      chk("jr_bare_upd_ovr", 32'(snap_ovr), 32'd2);
      consume("jr_consume");
      tx_data = 32'h0;
      xfer(1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D);
      chk("jr_new_data", snap_data, 32'hCAFEF00D);
      chk("jr_new_valid", 32'(snap_valid), 32'd1);
      chk("jr_new_ovr", 32'(snap_ovr), 32'd2);

      // Async reset mid-shift, between clk edges
      tx_data = 32'hFFFFFFFF;
      tck(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, t1, t2);
      for (int k = 0; k < 5; k++) tck(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, t1, t2);
      chk("rst_pre_jtdo2", 32'(t2), 32'd1);
      jce1 = 1'b0; jce2 = 1'b0; jshift = 1'b0;
      @(posedge clk);
      #5 rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_jtdo2", 32'(jtdo2), 32'd0);
      tx_data = 32'h0F0F0F0F;
      xfer(1'b0, 32'h600DF00D, 1'b0, 32'h600DF00D);
      chk("post_rst_data", snap_data, 32'h600DF00D);
      chk("post_rst_sel", 32'(snap_sel), 32'd0);
      chk("post_rst_valid", 32'(snap_valid), 32'd1);
      chk("post_rst_ovr", 32'(snap_ovr), 32'd0);
      chk("post_rst_tdo_seq", xfer_seq, 32'h0F0F0F0F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
